tlb_entry_array: RTL and testbench
==================================

// Module: tlb_entry_array
// PURPOSE
//  Fully-associative N-entry TLB data store feeding the TLB entry optimization barrier.
//  Accepts PTW refills over a valid/ready handshake and answers VPN lookups one cycle later.
//  Each answer carries hit plus the entry payload: ppn, u, ae_ptw, ae_final, pf, gf, sx, px.
//  Supports sfence invalidation, either global or by VPN.
// PARAMETERS
//  ENTRIES    8   number of entries; power of two, 2..32
//  VPN_BITS   27  virtual page number width (Sv39)
//  PPN_BITS   20  physical page number width; must match barrier io_x_ppn
// PORTS
//  clock          in   1          single clock, rising edge
//  reset          in   1          asynchronous, active-low; clears all state
//  lookup_valid   in   1          lookup request this cycle
//  lookup_vpn     in   VPN_BITS   VPN to translate
//  resp_valid     out  1          registered lookup_valid
//  resp_hit       out  1          a valid entry matched lookup_vpn
//  resp_data      out  PPN_BITS+7 tlb_entry_t {ppn,u,ae_ptw,ae_final,pf,gf,sx,px}; zero on miss
//  refill_valid   in   1          PTW response available
//  refill_ready   out  1          array accepts refill this cycle
//  refill_vpn     in   VPN_BITS   VPN of the refilled page
//  refill_data    in   PPN_BITS+7 tlb_entry_t payload to store
//  sfence_valid   in   1          invalidate request, single cycle
//  sfence_rs1     in   1          1: invalidate only sfence_vpn; 0: invalidate all
//  sfence_vpn     in   VPN_BITS   VPN for selective invalidate
//  occupancy      out  $clog2(ENTRIES+1)  count of valid entries
// BEHAVIOUR
//  - Reset values: valid[] = 0, repl_ptr = 0, resp_valid = 0, resp_hit = 0, resp_data = 0, occupancy = 0.
//    Tag and data storage are not reset.
//  - Lookup latency is 1 cycle.
//    resp_* register the compare of lookup_vpn against pre-edge state (valid, tag, data).
//    resp_* update every cycle; resp_hit = resp_data = 0 when lookup_valid = 0.
//  - A lookup and a write to the same VPN in the same cycle returns the OLD contents.
//    The new entry is visible from the following lookup.
//  - Refill handshake:
//    - Transfer happens when refill_valid && refill_ready.
//    - refill_ready = !sfence_valid (combinational; no dependency on refill_valid).
//    - refill_vpn and refill_data are held stable while valid && !ready.
//  - Victim selection on transfer:
//    1. If a valid entry already has tag == refill_vpn, overwrite it; no duplicates ever.
//    2. Else, the lowest-index invalid entry.
//    3. Else, the entry at repl_ptr; repl_ptr then advances by 1 mod ENTRIES.
//    repl_ptr changes only in case 3.
//  - sfence, applied at the clock edge:
//    - rs1 = 0: clear all valid bits.
//    - rs1 = 1: clear the valid bit of any entry whose tag == sfence_vpn.
//    - sfence has priority; no refill occurs in that cycle (ready is low).
//  - occupancy = popcount(valid), registered, consistent with valid[] after each edge; never exceeds ENTRIES.
//  - Reset mid-operation: all entries invalid immediately (asynchronous); a pending refill is dropped.
//    The PTW re-issues it after reset.
//  - resp_data field order matches the barrier io_x_* order, so the barrier connects bit-for-bit.
// STRUCTURE
//  - tlb_pkg:
//    - tlb_entry_t packed struct {ppn[PPN_BITS], u, ae_ptw, ae_final, pf, gf, sx, px}.
//    - TLB_VPN_BITS and TLB_PPN_BITS constants.
//    - Shared with the PTW and the barrier wrapper.
//  - Sub-module tlb_victim_sel (combinational):
//    - Inputs: valid[], tag-match vector, repl_ptr.
//    - Outputs: one-hot write-enable and advance_ptr.
//  - Top level holds the tag/data/valid flops, compare, response registers and occupancy.
// TESTING
//  1. Reset, then lookup vpn 0x1234 -> next cycle resp_valid = 1, resp_hit = 0, resp_data = 0, occupancy = 0.
//  2. Refill vpn 0x1234, ppn 0xABCDE, u = 1, px = 1 -> lookup 0x1234 hits with the same payload; occupancy = 1.
//  3. Refill 9 distinct VPNs (ENTRIES = 8) -> the 9th overwrites entry 0.
//     Lookup of the 1st VPN misses; occupancy stays 8; repl_ptr = 1.
//  4. Refill vpn 0x1234 twice with ppn 0x1 then 0x2 -> occupancy = 1; lookup returns ppn 0x2.
//  5. Assert sfence_valid and refill_valid together -> refill_ready = 0 and the refill is not taken.
//     rs1 = 1 on vpn 0x1234 leaves other VPNs hitting; rs1 = 0 -> occupancy = 0.
//  6. Lookup and refill of vpn 0x55 in the same cycle -> resp_hit = 0.
//     Lookup of 0x55 on the next cycle -> resp_hit = 1.
//     Async reset pulse mid-burst -> all lookups miss afterwards.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared TLB types and widths.
// Used by the PTW, the entry array and the barrier wrapper.
package tlb_pkg;

    localparam int TLB_VPN_BITS = 27;
    localparam int TLB_PPN_BITS = 20;
    localparam int TLB_ENTRIES  = 8;

    // Field order matches the barrier io_x_* order bit-for-bit.
    typedef struct packed {
        logic [TLB_PPN_BITS-1:0] ppn;
        logic                    u;
        logic                    ae_ptw;
        logic                    ae_final;
        logic                    pf;
        logic                    gf;
        logic                    sx;
        logic                    px;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_entry_array_if.sv
// Lookup, refill and sfence bundle of the TLB entry array.
// master = requester side, slave = array side.
interface tlb_entry_array_if #(
    parameter int ENTRIES  = 8,
    parameter int VPN_BITS = 27,
    parameter int PPN_BITS = 20
);

    logic                         lookup_valid;
    logic [VPN_BITS-1:0]          lookup_vpn;
    logic                         resp_valid;
    logic                         resp_hit;
    logic [PPN_BITS+6:0]          resp_data;
    logic                         refill_valid;
    logic                         refill_ready;
    logic [VPN_BITS-1:0]          refill_vpn;
    logic [PPN_BITS+6:0]          refill_data;
    logic                         sfence_valid;
    logic                         sfence_rs1;
    logic [VPN_BITS-1:0]          sfence_vpn;
    logic [$clog2(ENTRIES+1)-1:0] occupancy;

    modport master (
        output lookup_valid, lookup_vpn,
        input  resp_valid, resp_hit, resp_data,
        output refill_valid, refill_vpn, refill_data,
        input  refill_ready,
        output sfence_valid, sfence_rs1, sfence_vpn,
        input  occupancy
    );

    modport slave (
        input  lookup_valid, lookup_vpn,
        output resp_valid, resp_hit, resp_data,
        input  refill_valid, refill_vpn, refill_data,
        output refill_ready,
        input  sfence_valid, sfence_rs1, sfence_vpn,
        output occupancy
    );

endinterface

// File: rtl/tlb_victim_sel.sv
// Refill victim choice: existing tag match, else lowest free slot,
// else round-robin pointer.
module tlb_victim_sel #(
    parameter int ENTRIES = 8,
    parameter int PW      = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] valid,
    input  logic [ENTRIES-1:0] match,
    input  logic [PW-1:0]      repl_ptr,
    output logic [ENTRIES-1:0] we,
    output logic               advance_ptr
);

    logic [ENTRIES-1:0] free;

    assign free = ~valid;

    // Priority pick of the one-hot write enable.
    always_comb begin
        we          = '0;
        advance_ptr = 1'b0;
        if (|match) begin
            we = match;
        end else if (|free) begin
            // Lowest zero bit of valid is isolated by valid+1.
            we = free & (valid + 1'b1);
        end else begin
            we          = ENTRIES'(1) << repl_ptr;
            advance_ptr = 1'b1;
        end
    end

endmodule

// File: rtl/tlb_entry_array.sv
// Fully-associative TLB entry store: refill, 1-cycle lookup, sfence.
// Tag/data flops are not reset; only valid bits qualify them.
module tlb_entry_array
    import tlb_pkg::*;
#(
    parameter int ENTRIES  = TLB_ENTRIES,
    parameter int VPN_BITS = TLB_VPN_BITS,
    parameter int PPN_BITS = TLB_PPN_BITS
) (
    input  logic               clock,
    input  logic               reset,
    tlb_entry_array_if.slave   bus
);

    localparam int DW = PPN_BITS + 7;
    localparam int PW = $clog2(ENTRIES);
    localparam int OW = $clog2(ENTRIES + 1);

    logic [VPN_BITS-1:0] tag_q  [ENTRIES];
    logic [DW-1:0]       data_q [ENTRIES];
    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  valid_d;
    logic [ENTRIES-1:0]  lk_match;
    logic [ENTRIES-1:0]  rf_match;
    logic [ENTRIES-1:0]  sf_match;
    logic [ENTRIES-1:0]  we;
    logic [PW-1:0]       repl_ptr;
    logic                advance_ptr;
    logic                fire;
    logic [DW-1:0]       lk_data;
    logic [OW-1:0]       occ_d;
    logic [OW-1:0]       occ_q;
    logic                resp_valid_q;
    logic                resp_hit_q;
    logic [DW-1:0]       resp_data_q;

    assign bus.refill_ready = !bus.sfence_valid;
    assign fire             = bus.refill_valid && !bus.sfence_valid;

    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_hit     = resp_hit_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.occupancy    = occ_q;

    // Tag compares for lookup, refill and selective sfence.
    always_comb begin
        lk_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            lk_match[i] = valid_q[i] && (tag_q[i] == bus.lookup_vpn);
            rf_match[i] = valid_q[i] && (tag_q[i] == bus.refill_vpn);
            sf_match[i] = valid_q[i] && (tag_q[i] == bus.sfence_vpn);
            lk_data     = lk_data | (data_q[i] & {DW{lk_match[i]}});
        end
    end

    tlb_victim_sel #(
        .ENTRIES (ENTRIES),
        .PW      (PW)
    ) u_victim (
        .valid       (valid_q),
        .match       (rf_match),
        .repl_ptr    (repl_ptr),
        .we          (we),
        .advance_ptr (advance_ptr)
    );

    // Next valid vector and its population count.
    always_comb begin
        valid_d = valid_q;
        if (bus.sfence_valid) begin
            valid_d = bus.sfence_rs1 ? (valid_q & ~sf_match) : '0;
        end else if (fire) begin
            valid_d = valid_q | we;
        end
        occ_d = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occ_d = occ_d + OW'(valid_d[i]);
        end
    end

    // Control state: valid bits, pointer, occupancy, response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q      <= '0;
            repl_ptr     <= '0;
            occ_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            occ_q        <= occ_d;
            resp_valid_q <= bus.lookup_valid;
            resp_hit_q   <= bus.lookup_valid && (|lk_match);
            resp_data_q  <= bus.lookup_valid ? lk_data : '0;
            if (fire && advance_ptr) begin
                repl_ptr <= (repl_ptr == PW'(ENTRIES - 1)) ?
                            '0 : repl_ptr + 1'b1;
            end
        end
    end

    // Tag and payload storage written on an accepted refill.
    always_ff @(posedge clock) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (fire && we[i]) begin
                tag_q[i]  <= bus.refill_vpn;
                data_q[i] <= bus.refill_data;
            end
        end
    end

endmodule

// File: tb/tb_tlb_entry_array.sv
// Directed and random checks of tlb_entry_array against
// an associative reference model.
module tb_tlb_entry_array;
    import tlb_pkg::*;

    localparam int E = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    tlb_entry_array_if #(
        .ENTRIES  (E),
        .VPN_BITS (TLB_VPN_BITS),
        .PPN_BITS (TLB_PPN_BITS)
    ) bus ();

    tlb_entry_array #(
        .ENTRIES  (E),
        .VPN_BITS (TLB_VPN_BITS),
        .PPN_BITS (TLB_PPN_BITS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [TLB_VPN_BITS-1:0] m_tag [E];
    tlb_entry_t              m_data [E];
    bit                      m_valid [E];
    int                      m_ptr;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_find(input logic [TLB_VPN_BITS-1:0] v);
        for (int i = 0; i < E; i++)
            if (m_valid[i] && m_tag[i] == v) return i;
        return -1;
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < E; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < E; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic drive(input bit lv, input int lvpn,
                         input bit rv, input int rvpn, input tlb_entry_t rd,
                         input bit sv, input bit rs1, input int svpn);
        bus.lookup_valid = lv;
        bus.lookup_vpn   = TLB_VPN_BITS'(lvpn);
        bus.refill_valid = rv;
        bus.refill_vpn   = TLB_VPN_BITS'(rvpn);
        bus.refill_data  = rd;
        bus.sfence_valid = sv;
        bus.sfence_rs1   = rs1;
        bus.sfence_vpn   = TLB_VPN_BITS'(svpn);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, '0, 0, 0, 0);
    endtask

    function automatic tlb_entry_t mk(input int ppn, input bit u, input bit px);
        tlb_entry_t e;
        e     = '0;
        e.ppn = TLB_PPN_BITS'(ppn);
        e.u   = u;
        e.px  = px;
        return e;
    endfunction

    // One clock: check ready, predict, advance model, check outputs.
    task automatic step();
        bit         lv;
        bit         exp_hit;
        tlb_entry_t exp_d;
        int         idx;
        @(negedge clock);
        chk("refill_ready", 64'(bus.refill_ready), 64'(!bus.sfence_valid));
        lv      = bus.lookup_valid;
        idx     = m_find(bus.lookup_vpn);
        exp_hit = lv && idx >= 0;
        exp_d   = exp_hit ? m_data[idx] : '0;
        if (bus.sfence_valid) begin
            for (int i = 0; i < E; i++)
                if (!bus.sfence_rs1 || m_tag[i] == bus.sfence_vpn)
                    m_valid[i] = 1'b0;
        end else if (bus.refill_valid) begin
            idx = m_find(bus.refill_vpn);
            if (idx < 0)
                for (int i = E - 1; i >= 0; i--)
                    if (!m_valid[i]) idx = i;
            if (idx < 0) begin
                idx   = m_ptr;
                m_ptr = (m_ptr + 1) % E;
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = bus.refill_vpn;
            m_data[idx]  = bus.refill_data;
        end
        @(posedge clock);
        #1;
        chk("resp_valid", 64'(bus.resp_valid), 64'(lv));
        chk("resp_hit", 64'(bus.resp_hit), 64'(exp_hit));
        chk("resp_data", 64'(bus.resp_data), 64'(exp_d));
        chk("occupancy", 64'(bus.occupancy), 64'(m_occ()));
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #2;
        chk("async_occ", 64'(bus.occupancy), 64'd0);
        chk("async_resp_valid", 64'(bus.resp_valid), 64'd0);
        idle();
        reset = 1'b1;
        m_clear();
    endtask

    initial begin
        bit stalled;
        idle();
        m_clear();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_occ", 64'(bus.occupancy), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
        chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
        chk("rst_ptr", 64'(dut.repl_ptr), 64'd0);
        reset = 1'b1;

        // Miss after reset.
        drive(1, 'h1234, 0, 0, '0, 0, 0, 0);
        step();
        chk("t1_hit", 64'(bus.resp_hit), 64'd0);

        // Single refill then hit.
        drive(0, 0, 1, 'h1234, mk('hABCDE, 1, 1), 0, 0, 0);
        step();
        drive(1, 'h1234, 0, 0, '0, 0, 0, 0);
        step();
        chk("t2_hit", 64'(bus.resp_hit), 64'd1);
        chk("t2_data", 64'(bus.resp_data), 64'(mk('hABCDE, 1, 1)));
        chk("t2_occ", 64'(bus.occupancy), 64'd1);

        // Nine refills into eight entries.
        async_reset();
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 1, 'h100 + i, mk(i + 1, 0, 1), 0, 0, 0);
            step();
        end
        drive(1, 'h100, 0, 0, '0, 0, 0, 0);
        step();
        chk("t3_miss", 64'(bus.resp_hit), 64'd0);
        chk("t3_occ", 64'(bus.occupancy), 64'd8);
        chk("t3_ptr", 64'(dut.repl_ptr), 64'd1);
        drive(1, 'h108, 0, 0, '0, 0, 0, 0);
        step();
        chk("t3_ninth", 64'(bus.resp_hit), 64'd1);

        // Same VPN refilled twice.
        async_reset();
        drive(0, 0, 1, 'h1234, mk(1, 0, 0), 0, 0, 0);
        step();
        drive(0, 0, 1, 'h1234, mk(2, 0, 0), 0, 0, 0);
        step();
        drive(1, 'h1234, 0, 0, '0, 0, 0, 0);
        step();
        chk("t4_occ", 64'(bus.occupancy), 64'd1);
        chk("t4_ppn", 64'(bus.resp_data), 64'(mk(2, 0, 0)));

        // sfence blocks refill; selective then global flush.
        drive(0, 0, 1, 'h77, mk(7, 1, 0), 0, 0, 0);
        step();
        drive(0, 0, 1, 'h99, mk(9, 0, 0), 1, 1, 'h1234);
        #1;
        chk("t5_ready", 64'(bus.refill_ready), 64'd0);
        step();
        drive(1, 'h77, 0, 0, '0, 0, 0, 0);
        step();
        chk("t5_keep", 64'(bus.resp_hit), 64'd1);
        drive(1, 'h99, 0, 0, '0, 0, 0, 0);
        step();
        chk("t5_notaken", 64'(bus.resp_hit), 64'd0);
        drive(1, 'h1234, 0, 0, '0, 1, 0, 0);
        step();
        chk("t5_gone", 64'(bus.resp_hit), 64'd0);
        chk("t5_occ", 64'(bus.occupancy), 64'd0);

        // Same-cycle lookup and refill, then reset mid-burst.
        drive(1, 'h55, 1, 'h55, mk('h55, 1, 1), 0, 0, 0);
        step();
        chk("t6_old", 64'(bus.resp_hit), 64'd0);
        drive(1, 'h55, 0, 0, '0, 0, 0, 0);
        step();
        chk("t6_new", 64'(bus.resp_hit), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 'h200 + i, mk(i, 0, 0), 0, 0, 0);
            step();
        end
        drive(0, 0, 1, 'h203, mk(3, 0, 0), 0, 0, 0);
        async_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 'h200 + i, 0, 0, '0, 0, 0, 0);
            step();
            chk("t6_flushed", 64'(bus.resp_hit), 64'd0);
        end
        drive(1, 'h55, 0, 0, '0, 0, 0, 0);
        step();

        // Random traffic over a small VPN pool.
        stalled = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bus.lookup_valid = 1'($urandom_range(0, 3) != 0);
            bus.lookup_vpn   = TLB_VPN_BITS'($urandom_range(0, 15));
            if (!stalled) begin
                bus.refill_valid = 1'($urandom_range(0, 1));
                bus.refill_vpn   = TLB_VPN_BITS'($urandom_range(0, 15));
                bus.refill_data  = tlb_entry_t'(27'($urandom));
            end
            bus.sfence_valid = ($urandom_range(0, 19) == 0);
            bus.sfence_rs1   = 1'($urandom_range(0, 3) != 0);
            bus.sfence_vpn   = TLB_VPN_BITS'($urandom_range(0, 15));
            stalled          = bus.refill_valid && bus.sfence_valid;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
